// File: rtl/bypass_scoreboard.sv
// Operand bypass network with a long-latency scoreboard. It forwards the youngest
// matching stage result, flags hazards, tracks pending rd writes and counts stall cycles.
module bypass_scoreboard #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_STG-1:0]       stg_valid_i,
  input  logic [NUM_STG-1:0]       stg_rd_wr_en_i,
  input  logic [NUM_STG-1:0]       stg_data_rdy_i,
  input  logic [5*NUM_STG-1:0]     stg_rd_idx_i,
  input  logic [XLEN*NUM_STG-1:0]  stg_rd_data_i,
  input  logic [5*NUM_SRC-1:0]     rs_idx_i,
  input  logic [XLEN*NUM_SRC-1:0]  rs_data_i,
  input  logic [NUM_SRC-1:0]       rs_used_i,
  input  logic                     lng_issue_i,
  input  logic [4:0]               lng_issue_idx_i,
  input  logic                     lng_done_i,
  input  logic [4:0]               lng_done_idx_i,
  input  logic                     flush_i,
  output logic [XLEN*NUM_SRC-1:0]  rs_data_ao,
  output logic [NUM_SRC-1:0]       hazard_ao,
  output logic                     stall_ao,
  output logic                     lng_issue_rdy_ao,
  output logic [31:0]              pending_o,
  output logic [31:0]              stall_cnt_o
);

  logic [31:0]        pending_q;
  logic [31:0]        pending_nxt;
  logic [31:0]        stall_cnt_q;
  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] hit_rdy;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Walk from oldest to youngest so the youngest matching stage overwrites last.
  always_comb begin
    rs_data_ao = rs_data_i;
    hit        = '0;
    hit_rdy    = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_STG - 1; k >= 0; k--) begin
        if (stg_valid_i[k] && stg_rd_wr_en_i[k] && rs_used_i[s] &&
            (rs_idx_i[5*s +: 5] != 5'd0) &&
            (stg_rd_idx_i[5*k +: 5] == rs_idx_i[5*s +: 5])) begin
          hit[s]                      = 1'b1;
          hit_rdy[s]                  = stg_data_rdy_i[k];
          rs_data_ao[XLEN*s +: XLEN]  = stg_rd_data_i[XLEN*k +: XLEN];
        end
      end
    end
  end

  // A ready forwarded result hides a pending long-latency write to the same rd.
  always_comb begin
    hazard_ao = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      hazard_ao[s] = (hit[s] && !hit_rdy[s]) ||
                     (rs_used_i[s] && (rs_idx_i[5*s +: 5] != 5'd0) &&
                      pending_q[rs_idx_i[5*s +: 5]] && !(hit[s] && hit_rdy[s]));
    end
  end

  assign stall_ao         = |hazard_ao;
  assign lng_issue_rdy_ao = !pending_q[lng_issue_idx_i];
  assign pending_o        = pending_q;
  assign stall_cnt_o      = stall_cnt_q;

  // Issue is applied after done so a same-cycle issue/done pair leaves the bit set.
  always_comb begin
    pending_nxt = pending_q;
    if (lng_done_i) pending_nxt[lng_done_idx_i] = 1'b0;
    if (lng_issue_i && lng_issue_rdy_ao) pending_nxt[lng_issue_idx_i] = 1'b1;
    pending_nxt[0] = 1'b0;
    if (flush_i) pending_nxt = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q <= pending_nxt;
      if (stall_ao) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural scoreboard model.
module tb_bypass_scoreboard;
  localparam int XLEN    = 64;
  localparam int NUM_SRC = 2;
  localparam int NUM_STG = 3;

  logic                     clk = 1'b0;
  logic                     reset_i;
  logic [NUM_STG-1:0]       stg_valid_i, stg_rd_wr_en_i, stg_data_rdy_i;
  logic [5*NUM_STG-1:0]     stg_rd_idx_i;
  logic [XLEN*NUM_STG-1:0]  stg_rd_data_i;
  logic [5*NUM_SRC-1:0]     rs_idx_i;
  logic [XLEN*NUM_SRC-1:0]  rs_data_i;
  logic [NUM_SRC-1:0]       rs_used_i;
  logic                     lng_issue_i, lng_done_i, flush_i;
  logic [4:0]               lng_issue_idx_i, lng_done_idx_i;
  logic [XLEN*NUM_SRC-1:0]  rs_data_ao;
  logic [NUM_SRC-1:0]       hazard_ao;
  logic                     stall_ao, lng_issue_rdy_ao;
  logic [31:0]              pending_o, stall_cnt_o;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  bit   m_pend [32];
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  bypass_scoreboard #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .stg_valid_i(stg_valid_i), .stg_rd_wr_en_i(stg_rd_wr_en_i), .stg_data_rdy_i(stg_data_rdy_i),
    .stg_rd_idx_i(stg_rd_idx_i), .stg_rd_data_i(stg_rd_data_i),
    .rs_idx_i(rs_idx_i), .rs_data_i(rs_data_i), .rs_used_i(rs_used_i),
    .lng_issue_i(lng_issue_i), .lng_issue_idx_i(lng_issue_idx_i),
    .lng_done_i(lng_done_i), .lng_done_idx_i(lng_done_idx_i), .flush_i(flush_i),
    .rs_data_ao(rs_data_ao), .hazard_ao(hazard_ao), .stall_ao(stall_ao),
    .lng_issue_rdy_ao(lng_issue_rdy_ao), .pending_o(pending_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference: find the youngest matching stage, then apply the hazard rules directly.
  function automatic void model_src(input int s, output logic [XLEN-1:0] d, output logic h);
    int       first;
    logic [4:0] idx;
    logic     frdy;
    first = -1;
    idx   = rs_idx_i[5*s +: 5];
    for (int k = 0; k < NUM_STG; k++)
      if (first < 0 && stg_valid_i[k] && stg_rd_wr_en_i[k] && rs_used_i[s] &&
          idx != 5'd0 && stg_rd_idx_i[5*k +: 5] == idx)
        first = k;
    frdy = 1'b0;
    d    = rs_data_i[XLEN*s +: XLEN];
    if (first >= 0) begin
      frdy = stg_data_rdy_i[first];
      d    = stg_rd_data_i[XLEN*first +: XLEN];
    end
    h = (first >= 0 && !frdy) ||
        (rs_used_i[s] && idx != 5'd0 && m_pend[idx] && !(first >= 0 && frdy));
  endfunction

  function automatic logic model_stall();
    logic [XLEN-1:0] d;
    logic h;
    logic st;
    st = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      model_src(s, d, h);
      st = st | h;
    end
    return st;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_cnt = '0;
  endtask

  always @(posedge reset_i) model_clear();

  always @(posedge clk) begin
    bit ok;
    if (reset_i) model_clear();
    else begin
      if (model_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (flush_i) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      end else begin
        ok = !m_pend[lng_issue_idx_i];
        if (lng_done_i && lng_done_idx_i != 5'd0) m_pend[lng_done_idx_i] = 1'b0;
        if (lng_issue_i && ok && lng_issue_idx_i != 5'd0) m_pend[lng_issue_idx_i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [XLEN-1:0] d;
    logic h;
    if (chk_en) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        model_src(s, d, h);
        chk($sformatf("rs_data[%0d]", s), rs_data_ao[XLEN*s +: XLEN], d);
        chk($sformatf("hazard[%0d]", s), 64'(hazard_ao[s]), 64'(h));
      end
      chk("stall", 64'(stall_ao), 64'(model_stall()));
      chk("issue_rdy", 64'(lng_issue_rdy_ao), 64'(!m_pend[lng_issue_idx_i]));
      chk("pending", 64'(pending_o), 64'(m_vec()));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    end
  end

  task automatic set_idle();
    stg_valid_i = '0; stg_rd_wr_en_i = '0; stg_data_rdy_i = '0;
    stg_rd_idx_i = '0; stg_rd_data_i = '0;
    rs_idx_i = '0; rs_data_i = '0; rs_used_i = '0;
    lng_issue_i = 1'b0; lng_issue_idx_i = '0;
    lng_done_i = 1'b0; lng_done_idx_i = '0; flush_i = 1'b0;
  endtask

  task automatic set_stg(input int k, input logic v, input logic rdy, input logic [4:0] idx,
                         input logic [XLEN-1:0] data);
    stg_valid_i[k] = v; stg_rd_wr_en_i[k] = 1'b1; stg_data_rdy_i[k] = rdy;
    stg_rd_idx_i[5*k +: 5] = idx; stg_rd_data_i[XLEN*k +: XLEN] = data;
  endtask

  task automatic set_rs(input int s, input logic [4:0] idx, input logic [XLEN-1:0] data,
                        input logic used);
    rs_idx_i[5*s +: 5] = idx; rs_data_i[XLEN*s +: XLEN] = data; rs_used_i[s] = used;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    set_idle();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", 64'(pending_o), 64'h0);
    chk("rst_cnt", 64'(stall_cnt_o), 64'h0);
    chk("rst_rdy", 64'(lng_issue_rdy_ao), 64'h1);
    reset_i = 1'b0;
    chk_en  = 1'b1;

    // Youngest stage wins; dropping it exposes the older stage.
    set_stg(0, 1'b1, 1'b1, 5'd5, 64'hAAAA_0000_0000_000A);
    set_stg(1, 1'b1, 1'b1, 5'd5, 64'hBBBB_0000_0000_000B);
    set_rs(0, 5'd5, 64'h1111, 1'b1);
    @(negedge clk);
    chk("fwd_young", rs_data_ao[63:0], 64'hAAAA_0000_0000_000A);
    chk("fwd_young_hz", 64'(hazard_ao[0]), 64'h0);
    next_cycle();
    stg_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("fwd_old", rs_data_ao[63:0], 64'hBBBB_0000_0000_000B);

    // Not-ready youngest match stalls; an unused source does not.
    next_cycle(); set_idle();
    set_stg(0, 1'b1, 1'b0, 5'd7, 64'hC);
    set_rs(1, 5'd7, 64'h2222, 1'b1);
    @(negedge clk);
    chk("nrdy_hz", 64'(hazard_ao[1]), 64'h1);
    chk("nrdy_stall", 64'(stall_ao), 64'h1);
    next_cycle();
    rs_used_i[1] = 1'b0;
    @(negedge clk);
    chk("unused_hz", 64'(hazard_ao[1]), 64'h0);

    // Long-latency issue, WAW block, done.
    next_cycle(); set_idle();
    lng_issue_i = 1'b1; lng_issue_idx_i = 5'd9;
    @(negedge clk);
    chk("iss_rdy", 64'(lng_issue_rdy_ao), 64'h1);
    next_cycle(); set_idle();
    set_rs(0, 5'd9, 64'h3333, 1'b1);
    @(negedge clk);
    chk("pend_hz", 64'(hazard_ao[0]), 64'h1);
    chk("pend_vec", 64'(pending_o), 64'h200);
    next_cycle();
    lng_issue_i = 1'b1; lng_issue_idx_i = 5'd9;
    @(negedge clk);
    chk("waw_rdy", 64'(lng_issue_rdy_ao), 64'h0);
    next_cycle();
    lng_issue_i = 1'b0; lng_done_i = 1'b1; lng_done_idx_i = 5'd9;
    @(negedge clk);
    chk("done_same_cyc_hz", 64'(hazard_ao[0]), 64'h1);
    next_cycle();
    lng_done_i = 1'b0;
    @(negedge clk);
    chk("done_hz", 64'(hazard_ao[0]), 64'h0);
    chk("done_vec", 64'(pending_o), 64'h0);

    // Same-cycle issue/done keeps the bit; flush overrides issue.
    next_cycle(); set_idle();
    lng_issue_i = 1'b1; lng_issue_idx_i = 5'd3; lng_done_i = 1'b1; lng_done_idx_i = 5'd3;
    next_cycle(); set_idle();
    @(negedge clk);
    chk("iss_done_vec", 64'(pending_o), 64'h8);
    next_cycle();
    lng_issue_i = 1'b1; lng_issue_idx_i = 5'd4; flush_i = 1'b1;
    next_cycle(); set_idle();
    @(negedge clk);
    chk("flush_vec", 64'(pending_o), 64'h0);

    // x0 never forwards and is never pending.
    next_cycle();
    set_stg(0, 1'b1, 1'b0, 5'd0, 64'hDEAD);
    set_rs(0, 5'd0, 64'h1234, 1'b1);
    lng_issue_i = 1'b1; lng_issue_idx_i = 5'd0;
    @(negedge clk);
    chk("x0_data", rs_data_ao[63:0], 64'h1234);
    chk("x0_hz", 64'(hazard_ao[0]), 64'h0);
    next_cycle(); set_idle();
    @(negedge clk);
    chk("x0_vec", 64'(pending_o), 64'h0);

    // Counter saturation, then asynchronous reset mid-stall.
    next_cycle();
    set_stg(0, 1'b1, 1'b0, 5'd7, 64'hC);
    set_rs(1, 5'd7, 64'h2222, 1'b1);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("cnt_preload", 64'(stall_cnt_o), 64'hFFFF_FFFE);
    #1 release dut.stall_cnt_q;
    repeat (3) next_cycle();
    chk("cnt_sat", 64'(stall_cnt_o), 64'hFFFF_FFFF);
    reset_i = 1'b1;
    #1;
    chk("areset_cnt", 64'(stall_cnt_o), 64'h0);
    chk("areset_rdy", 64'(lng_issue_rdy_ao), 64'h1);
    @(negedge clk);
    chk("reset_hz", 64'(hazard_ao[1]), 64'h1);
    next_cycle();
    reset_i = 1'b0;

    // Random traffic on a narrow index range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      for (int k = 0; k < NUM_STG; k++)
        set_stg(k, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                {$urandom, $urandom});
      stg_rd_wr_en_i = NUM_STG'($urandom);
      for (int s = 0; s < NUM_SRC; s++)
        set_rs(s, 5'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom));
      lng_issue_i     = ($urandom_range(0, 2) == 0);
      lng_issue_idx_i = 5'($urandom_range(0, 7));
      lng_done_i      = ($urandom_range(0, 2) == 0);
      lng_done_idx_i  = 5'($urandom_range(0, 7));
      flush_i         = ($urandom_range(0, 19) == 0);
      reset_i         = (i == 1500);
      if (reset_i) begin
        #1;
        chk("rand_areset_pend", 64'(pending_o), 64'h0);
        chk("rand_areset_cnt", 64'(stall_cnt_o), 64'h0);
      end
    end
    next_cycle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bypass_scoreboard.md
BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand data width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source operands served (1..4).
REQ-003 SHALL have parameter NUM_STG, default 2, number of forwarding stages; index 0 is the youngest stage (1..4).
REQ-004 SHALL have: clk_i  in  1  single clock; reset_i  in  1  asynchronous active-high reset.
REQ-005 SHALL have: stg_valid_i, stg_rd_wr_en_i, stg_data_rdy_i  in  NUM_STG each  per-stage valid, writes-rd, rd data available this cycle.
REQ-006 SHALL have: stg_rd_idx_i  in  5*NUM_STG  and stg_rd_data_i  in  XLEN*NUM_STG  per-stage destination index and data, packed with stage k at slice k.
REQ-007 SHALL have: rs_idx_i  in  5*NUM_SRC; rs_data_i  in  XLEN*NUM_SRC; rs_used_i  in  NUM_SRC  per-source index, register-file data, used flag.
REQ-008 SHALL have: lng_issue_i  in  1; lng_issue_idx_i  in  5  long-latency op (divide, uncached load) issued to rd.
REQ-009 SHALL have: lng_done_i  in  1; lng_done_idx_i  in  5  long-latency op writes back rd this cycle.
REQ-010 SHALL have: flush_i  in  1  pipeline flush, kills all in-flight long-latency ops.
REQ-011 SHALL have: rs_data_ao  out  XLEN*NUM_SRC  forwarded operand data (combinational).
REQ-012 SHALL have: hazard_ao  out  NUM_SRC  per-source hazard; stall_ao  out  1  OR of hazard_ao.
REQ-013 SHALL have: lng_issue_rdy_ao  out  1  issue allowed; pending_o  out  32  registered pending mask; stall_cnt_o  out  32  registered stall-cycle count.

Function
REQ-014 Stage k SHALL match source s when stg_valid_i[k], stg_rd_wr_en_i[k], rs_used_i[s] are all 1, indices equal and the index is not 0.
REQ-015 rs_data_ao[s] SHALL be stg_rd_data_i of the lowest-numbered matching stage, else rs_data_i[s].
REQ-016 Source index 0 SHALL never match and SHALL output rs_data_i[s] unchanged.
REQ-017 hazard_ao[s] SHALL be 1 when the lowest-numbered matching stage has stg_data_rdy_i=0, regardless of older matching stages.
REQ-018 hazard_ao[s] SHALL also be 1 when rs_used_i[s]=1, rs_idx nonzero and pending_o[rs_idx]=1, unless a matching stage with stg_data_rdy_i=1 exists (forwarded result wins).
REQ-019 pending_o bit r SHALL set on the clock edge where lng_issue_i=1, lng_issue_rdy_ao=1, lng_issue_idx_i=r, r!=0.
REQ-020 pending_o bit r SHALL clear on the edge where lng_done_i=1 and lng_done_idx_i=r; done on a non-pending index SHALL have no effect.
REQ-021 Simultaneous issue and done to the same index SHALL leave the bit set (newer op wins).
REQ-022 lng_issue_rdy_ao SHALL be 0 when pending_o[lng_issue_idx_i]=1 (WAW block), else 1; issue while not ready SHALL be ignored.
REQ-023 Issue or done with index 0 SHALL be ignored; pending_o[0] SHALL always be 0.
REQ-024 flush_i=1 SHALL clear all pending_o bits on that edge, overriding same-cycle issue and done.
REQ-025 Forwarding and hazard outputs SHALL be combinational with zero latency; pending changes SHALL take effect the cycle after the edge.
REQ-026 stall_cnt_o SHALL increment by 1 on each edge where stall_ao=1 and SHALL saturate at 32'hFFFF_FFFF without wrap.
REQ-027 flush_i SHALL NOT clear stall_cnt_o.

Reset
REQ-028 reset_i=1 SHALL asynchronously force pending_o=0 and stall_cnt_o=0, including mid-operation.
REQ-029 During reset combinational outputs SHALL follow REQ-014..018 with pending_o=0; lng_issue_rdy_ao SHALL be 1.

Verification
REQ-030 Stage0 and stage1 both write x5 (A, B), rs0=x5 used, rdy0=1 -> rs_data_ao[0]=A, hazard 0; drop stage0 valid -> B.
REQ-031 Stage0 writes x7 with rdy0=0, rs1=x7 used -> hazard_ao[1]=1, stall_ao=1; rs_used_i[1]=0 -> hazard 0.
REQ-032 Issue x9, next cycle rs0=x9 -> hazard 1, issue x9 again -> rdy 0; done x9 -> next cycle hazard 0, pending_o=0.
REQ-033 Same cycle issue x3 and done x3 -> pending_o[3]=1; issue x4 with flush_i=1 -> pending_o=0.
REQ-034 Stage writes x0 data 0xDEAD, rs=x0 -> rs_data_ao=rs_data_i, no hazard; issue x0 -> pending_o stays 0.
REQ-035 Preload stall_cnt_o to 0xFFFF_FFFE via 2 stall... (force), hold stall 3 cycles -> 0xFFFF_FFFF held; assert reset_i mid-stall -> 0 immediately.
